// File: rtl/zbuf_depth_ctrl.sv
// Z-buffer depth-test controller: serialised read / compare / conditional write of
// fragments against an external depth RAM, plus a full-surface clear sequencer.
module zbuf_depth_ctrl #(
    parameter int unsigned            ADDR_WIDTH  = 16,
    parameter int unsigned            Z_WIDTH     = 16,
    parameter int unsigned            COLOR_WIDTH = 8,
    parameter logic [COLOR_WIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   frag_valid,
    output logic                   frag_ready,
    input  logic [ADDR_WIDTH-1:0]  frag_addr,
    input  logic [Z_WIDTH-1:0]     frag_z,
    input  logic [COLOR_WIDTH-1:0] frag_color,

    input  logic                   clear_start,
    output logic                   clear_busy,
    output logic                   clear_done,

    output logic [ADDR_WIDTH-1:0]  zram_read_addr,
    input  logic [Z_WIDTH-1:0]     zram_q,

    output logic [ADDR_WIDTH-1:0]  zram_write_addr,
    output logic [Z_WIDTH-1:0]     zram_data,
    output logic                   zram_we,

    output logic [ADDR_WIDTH-1:0]  cram_write_addr,
    output logic [COLOR_WIDTH-1:0] cram_data,
    output logic                   cram_we,

    output logic [31:0]            pass_cnt,
    output logic [31:0]            fail_cnt
);

    localparam int unsigned CNT_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RD    = 3'd2,
        CMP   = 3'd3,
        WR    = 3'd4
    } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [Z_WIDTH-1:0]     z;
        logic [COLOR_WIDTH-1:0] color;
    } frag_t;

    state_t state;
    state_t state_next;

    frag_t                  frag_q;
    frag_t                  frag_next;
    logic [ADDR_WIDTH-1:0]  clr_cnt;
    logic [ADDR_WIDTH-1:0]  clr_cnt_next;

    logic [ADDR_WIDTH-1:0]  read_addr_next;
    logic [ADDR_WIDTH-1:0]  write_addr_next;
    logic [Z_WIDTH-1:0]     zram_data_next;
    logic [COLOR_WIDTH-1:0] cram_data_next;
    logic                   we_next;
    logic                   busy_next;
    logic                   done_next;
    logic [CNT_WIDTH-1:0]   pass_cnt_next;
    logic [CNT_WIDTH-1:0]   fail_cnt_next;

    logic                   accept;

    // Clear has priority over fragments; nothing is accepted while in reset.
    assign frag_ready = rst_n && (state == IDLE) && !clear_start;
    assign accept     = frag_valid && frag_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (clear_start) begin
                    state_next = CLEAR;
                end else if (accept) begin
                    state_next = RD;
                end
            end
            CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            RD:      state_next = CMP;
            CMP:     state_next = WR;
            WR:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of every registered output and internal datapath register.
    always_comb begin
        frag_next       = frag_q;
        clr_cnt_next    = clr_cnt;
        read_addr_next  = zram_read_addr;
        write_addr_next = zram_write_addr;
        zram_data_next  = zram_data;
        cram_data_next  = cram_data;
        we_next         = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
        pass_cnt_next   = pass_cnt;
        fail_cnt_next   = fail_cnt;

        case (state)
            IDLE: begin
                if (clear_start) begin
                    clr_cnt_next    = '0;
                    write_addr_next = '0;
                    zram_data_next  = '1;
                    cram_data_next  = CLEAR_COLOR;
                    we_next         = 1'b1;
                    busy_next       = 1'b1;
                    pass_cnt_next   = '0;
                    fail_cnt_next   = '0;
                end else if (accept) begin
                    frag_next.addr  = frag_addr;
                    frag_next.z     = frag_z;
                    frag_next.color = frag_color;
                    read_addr_next  = frag_addr;
                end
            end
            CLEAR: begin
                // Counter tracks the address on the write port this cycle and wraps to 0 on exit.
                clr_cnt_next = clr_cnt + ADDR_WIDTH'(1);
                if (clr_cnt != LAST_ADDR) begin
                    write_addr_next = clr_cnt_next;
                    zram_data_next  = '1;
                    cram_data_next  = CLEAR_COLOR;
                    we_next         = 1'b1;
                    busy_next       = 1'b1;
                    done_next       = (clr_cnt_next == LAST_ADDR);
                end
            end
            CMP: begin
                we_next         = (frag_q.z < zram_q);
                write_addr_next = frag_q.addr;
                zram_data_next  = frag_q.z;
                cram_data_next  = frag_q.color;
            end
            WR: begin
                // The write enable held during WR is the depth-test result.
                if (zram_we) begin
                    if (pass_cnt != CNT_MAX) begin
                        pass_cnt_next = pass_cnt + CNT_WIDTH'(1);
                    end
                end else begin
                    if (fail_cnt != CNT_MAX) begin
                        fail_cnt_next = fail_cnt + CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frag_q          <= '0;
            clr_cnt         <= '0;
            zram_read_addr  <= '0;
            zram_write_addr <= '0;
            cram_write_addr <= '0;
            zram_data       <= '0;
            cram_data       <= '0;
            zram_we         <= 1'b0;
            cram_we         <= 1'b0;
            clear_busy      <= 1'b0;
            clear_done      <= 1'b0;
            pass_cnt        <= '0;
            fail_cnt        <= '0;
        end else begin
            frag_q          <= frag_next;
            clr_cnt         <= clr_cnt_next;
            zram_read_addr  <= read_addr_next;
            zram_write_addr <= write_addr_next;
            cram_write_addr <= write_addr_next;
            zram_data       <= zram_data_next;
            cram_data       <= cram_data_next;
            zram_we         <= we_next;
            cram_we         <= we_next;
            clear_busy      <= busy_next;
            clear_done      <= done_next;
            pass_cnt        <= pass_cnt_next;
            fail_cnt        <= fail_cnt_next;
        end
    end

endmodule
